// File: rtl/xilly_arb_pkg.sv
// Shared definitions for the Xillybus read-side burst arbiter.
// Contents: header magic, header field offsets, FSM state encodings and a
// header builder used by the arbiter when emitting a burst header word.
package xilly_arb_pkg;

  localparam logic [7:0] HdrMagic = 8'hA5;

  // Bit offsets of the header fields within the 128-bit header word.
  localparam int unsigned HdrMagicLsb = 120;
  localparam int unsigned HdrChLsb    = 112;
  localparam int unsigned HdrLenLsb   = 96;
  localparam int unsigned HdrSeqLsb   = 64;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHdr  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  function automatic logic [127:0] build_hdr(input logic [7:0]  ch,
                                             input logic [15:0] len,
                                             input logic [31:0] seq);
    logic [127:0] h;
    h = '0;
    h[HdrMagicLsb +: 8]  = HdrMagic;
    h[HdrChLsb +: 8]     = ch;
    h[HdrLenLsb +: 16]   = len;
    h[HdrSeqLsb +: 32]   = seq;
    return h;
  endfunction

endpackage

// File: rtl/xilly_arb_ofifo.sv
// Output FIFO for the read arbiter: standard (non-FWFT) FIFO with one cycle
// read latency. Writes are refused when full, reads are ignored when empty
// and the output register then holds its last value.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_en_i, wr_data_i    write strobe and data
//   full_o                no room for a write this cycle
//   rd_en_i               read strobe; data appears on rd_data_o next cycle
//   rd_data_o             registered read data (0 after reset)
//   empty_o               no word available
module xilly_arb_ofifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned Cw = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [Cw-1:0]    cnt_q, cnt_d;
  logic [Width-1:0] rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (cnt_q == Cw'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign rd_data_o = rd_data_q;

  always_comb begin
    // Full blocks a write even when a read frees a slot in the same cycle.
    wr_ok     = wr_en_i && !full_o;
    rd_ok     = rd_en_i && !empty_o;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == Aw'(Depth - 1)) ? '0 : wr_ptr_q + Aw'(1);
    end
    if (rd_ok) begin
      rd_ptr_d  = (rd_ptr_q == Aw'(Depth - 1)) ? '0 : rd_ptr_q + Aw'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + Cw'(1);
      2'b01:   cnt_d = cnt_q - Cw'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/xilly_rd_arbiter.sv
// Round-robin burst arbiter feeding a Xillybus 128-bit read stream.
// Each burst is one header word (magic, channel, length, per-channel sequence
// number) followed by up to BURST_MAX data words popped from one source FIFO.
// Ports:
//   bus_clk, rst            clock, synchronous active-high reset
//   src_count[NCH*6]        per-channel saturating words-available level
//   src_data[NCH*128]       per-channel FWFT head word
//   src_rden[NCH]           per-channel pop strobe
//   user_r_read_128_*       Xillybus read interface (rden, data, empty, eof, open)
module xilly_rd_arbiter
  import xilly_arb_pkg::*;
#(
  parameter int unsigned NCH         = 3,
  parameter int unsigned BURST_MAX   = 16,
  parameter int unsigned OFIFO_DEPTH = 8
) (
  input  logic               bus_clk,
  input  logic               rst,
  input  logic [NCH*6-1:0]   src_count,
  input  logic [NCH*128-1:0] src_data,
  output logic [NCH-1:0]     src_rden,
  input  logic               user_r_read_128_rden,
  output logic [127:0]       user_r_read_128_data,
  output logic               user_r_read_128_empty,
  output logic               user_r_read_128_eof,
  input  logic               user_r_read_128_open
);

  localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [1:0]        state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [ChW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       rem_q, rem_d;
  logic [NCH*32-1:0] seq_q, seq_d;

  logic              found;
  logic [ChW-1:0]    sel_ch;
  logic [5:0]        sel_cnt;
  logic [15:0]       sel_len;
  logic [127:0]      cur_data;
  logic [31:0]       cur_seq;
  logic              ofifo_full;
  logic              wr_en;
  logic [127:0]      wr_data;

  assign user_r_read_128_eof = 1'b0;

  // Round-robin scan starting just after the last served channel.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    sel_ch  = '0;
    sel_cnt = '0;
    for (int i = 1; i <= int'(NCH); i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NCH)) idx = idx - int'(NCH);
      if (!found && (src_count[idx*6 +: 6] != 6'd0)) begin
        found   = 1'b1;
        sel_ch  = ChW'(idx);
        sel_cnt = src_count[idx*6 +: 6];
      end
    end
    sel_len = (16'(sel_cnt) > 16'(BURST_MAX)) ? 16'(BURST_MAX) : 16'(sel_cnt);
  end

  assign cur_data = src_data[int'(ch_q)*128 +: 128];
  assign cur_seq  = seq_q[int'(ch_q)*32 +: 32];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    len_d    = len_q;
    rem_d    = rem_q;
    seq_d    = seq_q;
    src_rden = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (state_q)
      StIdle: begin
        if (user_r_read_128_open && found) begin
          ch_d    = sel_ch;
          len_d   = sel_len;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (!ofifo_full) begin
          wr_en   = 1'b1;
          wr_data = build_hdr(8'(ch_q), len_q, cur_seq);
          seq_d[int'(ch_q)*32 +: 32] = cur_seq + 32'd1;
          rem_d   = len_q;
          state_d = StData;
        end
      end
      StData: begin
        // open is deliberately ignored here: a started burst always completes.
        if (!ofifo_full) begin
          src_rden[ch_q] = 1'b1;
          wr_en          = 1'b1;
          wr_data        = cur_data;
          rem_d          = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            rr_ptr_d = ch_q;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // No pop may escape in a reset cycle; the burst is simply discarded.
    if (rst) begin
      src_rden = '0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      rr_ptr_q <= ChW'(NCH - 1);
      len_q    <= '0;
      rem_q    <= '0;
      seq_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rr_ptr_q <= rr_ptr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      seq_q    <= seq_d;
    end
  end

  xilly_arb_ofifo #(
    .Depth(OFIFO_DEPTH),
    .Width(128)
  ) u_ofifo (
    .clk_i    (bus_clk),
    .rst_i    (rst),
    .wr_en_i  (wr_en),
    .wr_data_i(wr_data),
    .full_o   (ofifo_full),
    .rd_en_i  (user_r_read_128_rden),
    .rd_data_o(user_r_read_128_data),
    .empty_o  (user_r_read_128_empty)
  );

endmodule

// File: doc/xilly_rd_arbiter.md
XILLY_RD_ARBITER -- requirements
Module: xilly_rd_arbiter

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have parameter NCH, default 3, meaning number of source channels.
REQ-003 SHALL have parameter BURST_MAX, default 16, meaning maximum data words per burst.
REQ-004 SHALL have parameter OFIFO_DEPTH, default 8, meaning output FIFO depth in words.
REQ-005 SHALL have port bus_clk, input, 1 bit: clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port src_count, input, NCH*6 bits: per-channel saturating words-available level, a lower bound on the source level.
REQ-008 SHALL have port src_data, input, NCH*128 bits: per-channel first-word-fall-through head word.
REQ-009 SHALL have port src_rden, output, NCH bits: per-channel pop strobe.
REQ-010 SHALL have port user_r_read_128_rden, input, 1 bit: Xillybus read strobe.
REQ-011 SHALL have port user_r_read_128_data, output, 128 bits: data, valid one cycle after rden (standard FIFO).
REQ-012 SHALL have port user_r_read_128_empty, output, 1 bit: output FIFO empty.
REQ-013 SHALL have port user_r_read_128_eof, output, 1 bit: constant 0.
REQ-014 SHALL have port user_r_read_128_open, input, 1 bit: host file open.

Function
REQ-015 SHALL implement FSM states IDLE, HDR and DATA.
REQ-016 In IDLE with open=1, SHALL select the first channel with src_count>=1, scanning round-robin from rr_ptr+1 modulo NCH; SHALL latch ch and len=min(src_count[ch],BURST_MAX); SHALL go to HDR.
REQ-017 In IDLE with open=0 or no eligible channel, SHALL remain in IDLE.
REQ-018 In HDR with ofifo not full, SHALL write the header and go to DATA; otherwise SHALL hold.
REQ-019 Header layout: [127:120]=8'hA5, [119:112]=ch, [111:96]=len, [95:64]=seq[ch], [63:0]=0.
REQ-020 After the header is written, SHALL increment seq[ch], 32 bits, wrapping 0xFFFFFFFF->0.
REQ-021 In DATA with ofifo not full, SHALL assert src_rden[ch] and write src_data[ch] in the same cycle, then decrement the remaining count.
REQ-022 On the last word, SHALL set rr_ptr=ch and go to IDLE; the next burst may start in the following cycle.
REQ-023 At most one src_rden bit SHALL be high at a time, and only in DATA.
REQ-024 Deassertion of open mid-burst SHALL NOT abort the burst; the burst SHALL complete into the ofifo.
REQ-025 Ofifo write SHALL be blocked when full, even if a read occurs in the same cycle.
REQ-026 Ofifo read when empty SHALL be ignored, with data held.
REQ-027 Simultaneous read and write when neither full nor empty SHALL keep the level unchanged.

Reset
REQ-028 Reset SHALL force the FSM to IDLE, rr_ptr=NCH-1 so ch0 wins first, all seq=0, ofifo emptied, src_rden=0, user_r_read_128_empty=1, user_r_read_128_data=0.
REQ-029 Reset mid-burst SHALL discard the burst, take priority over all other events, and issue no src_rden in the reset cycle.

Structure
REQ-030 SHALL place header magic 8'hA5, the field offsets and the FSM state enum in shared package xilly_arb_pkg.
REQ-031 SHALL implement the output FIFO as sub-module xilly_arb_ofifo: 128-bit, standard read latency 1, full/empty outputs.

Verification
REQ-032 With src_count={0,0,5}, open=1, and rden held high, SHALL produce a host stream of header ch=2 len=5 seq=0 followed by 5 data words, with exactly 5 src_rden[2] pulses.
REQ-033 With all three channels at count=40, SHALL produce bursts in order ch0, ch1, ch2, ch0, each of len=16, with seq per channel 0, 0, 0, 1.
REQ-034 With host rden=0, SHALL stop the ofifo after 8 words and keep src_rden low; resuming rden SHALL deliver the stream with no loss or duplication.
REQ-035 Asserting rst during the 3rd data word of a burst SHALL give, the next cycle, empty=1 and src_rden=0, and the next burst SHALL have seq=0 and ch0 priority.
REQ-036 With open=0 and count=4 on ch1, SHALL start no burst; setting open=1 SHALL produce a burst on ch1 within 2 cycles.
REQ-037 After forcing seq[0]=0xFFFFFFFF, the header SHALL show 0xFFFFFFFF and the next ch0 header SHALL show 0.
